// File: rtl/seg7_scan_ctrl.sv
// Eight-digit seven-segment scan controller: double-buffered 32-bit number,
// one digit per DIV-cycle slot with a DEAD-cycle blanking tail, optional leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int unsigned DIV  = 100000,
    parameter int unsigned DEAD = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_en,
    input  logic [31:0] num_in,
    input  logic        lzb,
    output logic [7:0]  digits,
    output logic [6:0]  seg,
    output logic        frame_done
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] SHOW_LAST = CW'(DIV - DEAD - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(DIV - 1);

    typedef enum logic [1:0] {ST_OFF, ST_SHOW, ST_GAP} state_e;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] active_q, active_d;
    logic [31:0] pending_q, pending_d;
    logic [7:0]  digits_q, digits_d;
    logic [6:0]  seg_q, seg_d;
    logic        frame_done_q, frame_done_d;
    logic        slot_end;
    logic        lead_zero;
    logic [3:0]  nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0111111;
            4'h1: hex7 = 7'b0000110;
            4'h2: hex7 = 7'b1011011;
            4'h3: hex7 = 7'b1001111;
            4'h4: hex7 = 7'b1100110;
            4'h5: hex7 = 7'b1101101;
            4'h6: hex7 = 7'b1111101;
            4'h7: hex7 = 7'b0000111;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1101111;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b1111100;
            4'hC: hex7 = 7'b0111001;
            4'hD: hex7 = 7'b1011110;
            4'hE: hex7 = 7'b1111001;
            default: hex7 = 7'b1110001;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        pending_d    = wr_en ? num_in : pending_q;
        frame_done_d = 1'b0;
        slot_end     = 1'b0;

        if (!en) begin
            state_d = ST_OFF;
            idx_d   = 3'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d  = ST_SHOW;
                    idx_d    = 3'd0;
                    cnt_d    = '0;
                    active_d = pending_q;
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        if (DEAD > 0) begin
                            state_d = ST_GAP;
                            cnt_d   = cnt_q + 1'b1;
                        end else begin
                            slot_end = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) slot_end = 1'b1;
                    else                   cnt_d = cnt_q + 1'b1;
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end
            endcase
        end

        if (slot_end) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                frame_done_d = 1'b1;
                active_d     = pending_q;
            end
        end

        // Outputs are derived from next-cycle state so they are valid from the first SHOW cycle.
        nib       = active_d[{idx_d, 2'b00} +: 4];
        lead_zero = lzb && (idx_d != 3'd0) && ((active_d >> {idx_d, 2'b00}) == 32'd0);
        if (state_d == ST_SHOW && !lead_zero) begin
            digits_d = 8'd1 << idx_d;
            seg_d    = hex7(nib);
        end else begin
            digits_d = 8'd0;
            seg_d    = 7'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_OFF;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            active_q     <= 32'd0;
            pending_q    <= 32'd0;
            digits_q     <= 8'd0;
            seg_q        <= 7'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            digits_q     <= digits_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digits     = digits_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (DEAD=2 and DEAD=0) checked each cycle
// against a time-since-enable reference model.
module tb_seg7_scan_ctrl;
    localparam int DIV   = 8;
    localparam int DEAD0 = 2;
    localparam int FRAME = 8 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, wr_en = 1'b0, lzb = 1'b0;
    logic [31:0] num_in = 32'd0;
    logic [1:0][7:0] dig;
    logic [1:0][6:0] sg;
    logic [1:0]      fd;

    int n_cmp = 0, n_err = 0;

    // reference model state
    bit          running;
    int          t;
    logic [31:0] m_active, m_pending;
    logic        exp_fd;
    logic [7:0]  exp_dig [2];
    logic [6:0]  exp_seg [2];

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIV(DIV), .DEAD(DEAD0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .num_in(num_in), .lzb(lzb),
        .digits(dig[0]), .seg(sg[0]), .frame_done(fd[0]));
    seg7_scan_ctrl #(.DIV(DIV), .DEAD(0)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .num_in(num_in), .lzb(lzb),
        .digits(dig[1]), .seg(sg[1]), .frame_done(fd[1]));

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;  3: return 7'b1001111;
            4: return 7'b1100110;  5: return 7'b1101101;  6: return 7'b1111101;  7: return 7'b0000111;
            8: return 7'b1111111;  9: return 7'b1101111; 10: return 7'b1110111; 11: return 7'b1111100;
            12: return 7'b0111001; 13: return 7'b1011110; 14: return 7'b1111001; default: return 7'b1110001;
        endcase
    endfunction

    // Advance one clock with the currently driven inputs and update the model.
    task automatic tick();
        int d, pos, dd;
        bit show, blank;
        @(posedge clk);
        exp_fd = 1'b0;
        if (rst) begin
            running = 0; t = 0; m_active = 0; m_pending = 0;
        end else begin
            if (!en) begin
                running = 0; t = 0;
            end else if (!running) begin
                running = 1; t = 0; m_active = m_pending;
            end else begin
                t++;
                if (t % FRAME == 0) begin m_active = m_pending; exp_fd = 1'b1; end
            end
            if (wr_en) m_pending = num_in;
        end
        d   = (t / DIV) % 8;
        pos = t % DIV;
        for (int k = 0; k < 2; k++) begin
            dd    = (k == 0) ? DEAD0 : 0;
            show  = running && (pos < DIV - dd);
            blank = lzb && (d > 0) && ((m_active >> (4 * d)) == 0);
            exp_dig[k] = (show && !blank) ? 8'(1 << d) : 8'd0;
            exp_seg[k] = (show && !blank) ? glyph(int'((m_active >> (4 * d)) & 32'hF)) : 7'd0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; wr_en = 1'b1; num_in = 32'hDEADBEEF;
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (dig[k] !== 8'd0 || sg[k] !== 7'd0 || fd[k] !== 1'b0) begin
                n_err++;
                $display("FAIL reset inst%0d: got digits=%h seg=%b fd=%b, want all zero", k, dig[k], sg[k], fd[k]);
            end
        end
        rst = 1'b0; en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_basic();
        int last_fd = -1, cyc = 0;
        en = 1'b1; tick();
        wr_en = 1'b1; num_in = 32'h12345678; tick(); wr_en = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick(); cyc++;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (dig[k] !== exp_dig[k] || sg[k] !== exp_seg[k] || fd[k] !== exp_fd) begin
                    n_err++;
                    $display("FAIL basic inst%0d t=%0d: got %h/%b/%b want %h/%b/%b", k, t, dig[k], sg[k], fd[k], exp_dig[k], exp_seg[k], exp_fd);
                end
            end
            if (fd[0] === 1'b1) begin
                if (last_fd >= 0) begin
                    n_cmp++;
                    if (cyc - last_fd != FRAME) begin
                        n_err++;
                        $display("FAIL frame_period: got %0d cycles want %0d", cyc - last_fd, FRAME);
                    end
                end
                last_fd = cyc;
            end
        end
    endtask

    task automatic test_tear();
        for (int i = 0; i < 2 * FRAME && (t % FRAME) != 20; i++) tick();
        wr_en = 1'b1; num_in = 32'hAAAAAAAA; tick(); wr_en = 1'b0;
        for (int i = 0; i < 2 * FRAME && (t % FRAME) != FRAME - 3; i++) tick();
        n_cmp++;
        if ((t % FRAME) != FRAME - 3) begin n_err++; $display("FAIL tear_wait: t=%0d never reached", t); end
        wr_en = 1'b1; num_in = 32'h55555555; tick(); wr_en = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (dig[k] !== exp_dig[k] || sg[k] !== exp_seg[k] || fd[k] !== exp_fd) begin
                    n_err++;
                    $display("FAIL tear inst%0d t=%0d: got %h/%b/%b want %h/%b/%b", k, t, dig[k], sg[k], fd[k], exp_dig[k], exp_seg[k], exp_fd);
                end
            end
            if (i >= FRAME && exp_dig[1] != 0) begin
                n_cmp++;
                if (sg[1] !== 7'b1101101) begin n_err++; $display("FAIL tear_five: got seg=%b want 1101101", sg[1]); end
            end
        end
    endtask

    task automatic test_boundary_write();
        wr_en = 1'b1; num_in = 32'h11111111; tick(); wr_en = 1'b0;
        for (int i = 0; i < 2 * FRAME && !exp_fd; i++) tick();
        n_cmp++;
        if (fd[0] !== 1'b1) begin n_err++; $display("FAIL boundary_pulse: got fd=%b want 1", fd[0]); end
        // frame_done is high now; this write lands after the boundary
        wr_en = 1'b1; num_in = 32'hFFFF0000; tick(); wr_en = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (dig[k] !== exp_dig[k] || sg[k] !== exp_seg[k] || fd[k] !== exp_fd) begin
                    n_err++;
                    $display("FAIL boundary inst%0d t=%0d: got %h/%b/%b want %h/%b/%b", k, t, dig[k], sg[k], fd[k], exp_dig[k], exp_seg[k], exp_fd);
                end
            end
        end
    endtask

    task automatic test_lzb();
        lzb = 1'b1;
        wr_en = 1'b1; num_in = 32'h00000305; tick(); wr_en = 1'b0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (dig[k] !== exp_dig[k] || sg[k] !== exp_seg[k] || fd[k] !== exp_fd) begin
                    n_err++;
                    $display("FAIL lzb305 inst%0d t=%0d: got %h/%b/%b want %h/%b/%b", k, t, dig[k], sg[k], fd[k], exp_dig[k], exp_seg[k], exp_fd);
                end
            end
        end
        wr_en = 1'b1; num_in = 32'h0; tick(); wr_en = 1'b0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (dig[k] !== exp_dig[k] || sg[k] !== exp_seg[k] || fd[k] !== exp_fd) begin
                    n_err++;
                    $display("FAIL lzb0 inst%0d t=%0d: got %h/%b/%b want %h/%b/%b", k, t, dig[k], sg[k], fd[k], exp_dig[k], exp_seg[k], exp_fd);
                end
            end
            if (i >= FRAME && dig[1] === 8'h01) begin
                n_cmp++;
                if (sg[1] !== 7'b0111111) begin n_err++; $display("FAIL lzb_zero_glyph: got seg=%b want 0111111", sg[1]); end
            end
        end
        lzb = 1'b0;
    endtask

    task automatic test_en_drop();
        int pulses = 0;
        wr_en = 1'b1; num_in = 32'h87654321; tick(); wr_en = 1'b0;
        for (int i = 0; i < 2 * FRAME && (t % FRAME) != 4 * DIV + 1; i++) tick();
        en = 1'b0; tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (dig[k] !== 8'd0 || sg[k] !== 7'd0 || fd[k] !== 1'b0) begin
                n_err++;
                $display("FAIL en_drop inst%0d: got %h/%b/%b want 00/0000000/0", k, dig[k], sg[k], fd[k]);
            end
        end
        wr_en = 1'b1; num_in = 32'h9ABCDEF0; tick(); wr_en = 1'b0;
        tick(); if (fd[0] === 1'b1) pulses++;
        en = 1'b1;
        for (int i = 0; i < FRAME + 8; i++) begin
            tick();
            if (i < FRAME - 1 && fd[0] === 1'b1) pulses++;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (dig[k] !== exp_dig[k] || sg[k] !== exp_seg[k] || fd[k] !== exp_fd) begin
                    n_err++;
                    $display("FAIL en_restart inst%0d t=%0d: got %h/%b/%b want %h/%b/%b", k, t, dig[k], sg[k], fd[k], exp_dig[k], exp_seg[k], exp_fd);
                end
            end
        end
        n_cmp++;
        if (pulses != 0) begin n_err++; $display("FAIL en_no_pulse: got %0d frame_done pulses want 0", pulses); end
    endtask

    task automatic test_rst_mid_gap();
        for (int i = 0; i < 2 * FRAME && (t % DIV) != DIV - 1; i++) tick();
        n_cmp++;
        if (dig[0] !== 8'd0 || dig[1] === 8'd0) begin
            n_err++;
            $display("FAIL gap_vs_nogap: got dig0=%h dig1=%h want dig0=00 dig1 lit", dig[0], dig[1]);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (dig[k] !== 8'd0 || sg[k] !== 7'd0 || fd[k] !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid inst%0d: got %h/%b/%b want all zero", k, dig[k], sg[k], fd[k]);
            end
        end
        for (int i = 0; i < FRAME + 4; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (dig[k] !== exp_dig[k] || sg[k] !== exp_seg[k] || fd[k] !== exp_fd) begin
                    n_err++;
                    $display("FAIL after_rst inst%0d t=%0d: got %h/%b/%b want %h/%b/%b", k, t, dig[k], sg[k], fd[k], exp_dig[k], exp_seg[k], exp_fd);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            wr_en  = ($urandom_range(0, 15) == 0);
            num_in = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h000F0F0F) : $urandom;
            if ($urandom_range(0, 31) == 0) lzb = ~lzb;
            en = ($urandom_range(0, 199) != 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (dig[k] !== exp_dig[k] || sg[k] !== exp_seg[k] || fd[k] !== exp_fd) begin
                    n_err++;
                    $display("FAIL random inst%0d t=%0d: got %h/%b/%b want %h/%b/%b", k, t, dig[k], sg[k], fd[k], exp_dig[k], exp_seg[k], exp_fd);
                end
            end
        end
        wr_en = 1'b0; en = 1'b1; lzb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tear();
        test_boundary_write();
        test_lzb();
        test_en_drop();
        test_rst_mid_gap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
